fp32_add_ctrl: RTL and testbench

Requester side of the FP32 adder's load/done interface. Accepts operand pairs on a valid/ready request channel and optionally negates operand B for subtraction. Pulses the adder's load line for one cycle, waits for done, and captures the adder result. Returns the result plus classification flags on a valid/ready response channel.

---
 rtl/fp32_add_ctrl.sv | 154 +++++++++++++++
 tb/tb_fp32_add_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_add_ctrl.sv
// fp32_add_ctrl: requester side of the FP32 adder load/done handshake.
// Takes operand pairs on a valid/ready request channel (optional B negation
// for subtraction), pulses add_load for one cycle, waits for add_done and
// returns the captured result plus {timeout, nan, inf, zero} flags on a
// valid/ready response channel.
// Optional feature macro: FP_ADD_CTRL_TIMEOUT_EN (WAIT-state abort after
// TIMEOUT_CYCLES cycles with a quiet-NaN result and the timeout flag).
module fp32_add_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_z,
  output logic [3:0]  rsp_flags,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_load,
  input  logic [31:0] add_z,
  input  logic        add_done
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fp32_add_ctrl: TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic        idle_rdy_q;   // request ready while idle; low during and just after reset
  logic        blank_q;      // masks add_done in the first WAIT cycle
  logic        accept;
  logic        capture;
  logic        abort;
  logic [2:0]  cls_q;        // {nan, inf, zero}

`ifdef FP_ADD_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       to_q;
`endif

  // In RESP the ready follows the consumer directly so a result can be
  // retired and a new request taken on the same edge.
  assign req_ready = (state == RESP) ? rsp_ready : idle_rdy_q;

`ifdef FP_ADD_CTRL_TIMEOUT_EN
  assign rsp_flags = {to_q, cls_q};
`else
  assign rsp_flags = {1'b0, cls_q};
`endif

  // Next-state decode and single-cycle event strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (idle_rdy_q && req_valid) begin
          accept   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = WAIT;
      WAIT: begin
        if (!blank_q && add_done) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
`ifdef FP_ADD_CTRL_TIMEOUT_EN
        else if (wait_cnt == TO_LAST) begin
          abort    = 1'b1;
          state_nx = RESP;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          if (req_valid) begin
            accept   = 1'b1;
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idle_rdy_q <= 1'b0;
      blank_q    <= 1'b0;
      add_load   <= 1'b0;
      rsp_valid  <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      rsp_z      <= '0;
      cls_q      <= '0;
    end else begin
      state      <= state_nx;
      idle_rdy_q <= (state_nx == IDLE);
      blank_q    <= (state == LOAD);
      add_load   <= (state_nx == LOAD);
      rsp_valid  <= (state_nx == RESP);
      if (accept) begin
        add_a <= req_a;
        add_b <= {req_b[31] ^ req_sub, req_b[30:0]};
      end
      if (capture) begin
        rsp_z    <= add_z;
        cls_q[2] <= (add_z[30:23] == 8'hFF) && (add_z[22:0] != '0);
        cls_q[1] <= (add_z[30:23] == 8'hFF) && (add_z[22:0] == '0);
        cls_q[0] <= (add_z[30:23] == 8'h00) && (add_z[22:0] == '0);
      end else if (abort) begin
        rsp_z <= 32'h7FC0_0000;
        cls_q <= 3'b100;
      end
    end
  end

`ifdef FP_ADD_CTRL_TIMEOUT_EN
  // WAIT-cycle counter and timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      if (state == LOAD) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (capture) begin
        to_q <= 1'b0;
      end else if (abort) begin
        to_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp32_add_ctrl.sv
// Directed self-checking bench for fp32_add_ctrl with a simple adder model
// that raises done a fixed number of cycles after it sees add_load.
module tb_fp32_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_sub;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_z;
  logic [3:0]  rsp_flags;
  logic [31:0] add_a, add_b, add_z;
  logic        add_load, add_done;

  logic [31:0] model_z;
  logic        model_en;
  logic        model_done = 1'b0;
  logic        force_done;
  logic [7:0]  mcnt = 8'd0;
  localparam logic [7:0] MODEL_K = 8'd5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_add_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_flags(rsp_flags),
    .add_a(add_a), .add_b(add_b), .add_load(add_load),
    .add_z(add_z), .add_done(add_done)
  );

  assign add_z    = model_z;
  assign add_done = model_done | force_done;

  // Adder model: done pulses for one cycle, sampled by the DUT on the 6th
  // edge after the edge that saw add_load.
  always @(posedge clk) begin
    if (add_load) mcnt <= 8'd1;
    else if (mcnt != 8'd0) mcnt <= (mcnt == MODEL_K) ? 8'd0 : mcnt + 8'd1;
    model_done <= model_en && (mcnt == MODEL_K);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one edge after acceptance; waits for rsp_valid and checks latency.
  task automatic wait_rsp(input string tag, input int exp_lat,
                          input logic [31:0] exp_z, input logic [3:0] exp_f);
    int n;
    n = 1;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_z"}, rsp_z, exp_z);
    chk({tag, "_flags"}, {28'd0, rsp_flags}, {28'd0, exp_f});
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] z, input logic [31:0] exp_b,
                       input logic [31:0] exp_z, input logic [3:0] exp_f, input logic hold);
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1; model_z = z;
    chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_sub = ~sub;
    chk({tag, "_load1"}, {31'd0, add_load}, 32'd1);
    chk({tag, "_add_b"}, add_b, exp_b);
    tick();
    chk({tag, "_load0"}, {31'd0, add_load}, 32'd0);
    chk({tag, "_add_a"}, add_a, a);
    wait_rsp(tag, 7, exp_z, exp_f);
    if (!hold) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_drop"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    end
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0;
    rsp_ready = 1'b0; model_z = '0; model_en = 1'b1; force_done = 1'b0;
    #3;
    chk("rst_ctl", {25'd0, req_ready, rsp_valid, add_load, rsp_flags}, 32'd0);
    chk("rst_z", rsp_z, 32'd0);
    chk("rst_ab", add_a | add_b, 32'd0);
    #9 rst_n = 1'b1;
    tick();
    chk("idle_rdy", {31'd0, req_ready}, 32'd1);

    do_op("add", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000,
          32'h4000_0000, 32'h4040_0000, 4'b0000, 1'b0);
    do_op("sub", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000,
          32'hBF80_0000, 32'h4000_0000, 4'b0000, 1'b0);
    do_op("nan", 32'h0, 32'h0, 1'b0, 32'h7FC0_0000, 32'h0, 32'h7FC0_0000, 4'b0100, 1'b0);
    do_op("inf", 32'h0, 32'h0, 1'b1, 32'hFF80_0000, 32'h8000_0000, 32'hFF80_0000, 4'b0010, 1'b0);
    do_op("zero", 32'h0, 32'h0, 1'b0, 32'h8000_0000, 32'h0, 32'h8000_0000, 4'b0001, 1'b0);

    // Backpressure then back-to-back request
    do_op("bp", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000,
          32'h4000_0000, 32'h4080_0000, 4'b0000, 1'b1);
    model_z = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {rsp_valid, req_ready, rsp_flags, 26'd0}, 32'h8000_0000);
      chk("bp_z", rsp_z, 32'h4080_0000);
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_a = 32'h4100_0000; req_b = 32'h3F80_0000;
    req_sub = 1'b1; model_z = 32'h40E0_0000;
    #1;
    chk("b2b_rdy", {31'd0, req_ready}, 32'd1);
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("b2b_load", {29'd0, add_load, rsp_valid, req_ready}, 32'd4);
    chk("b2b_a", add_a, 32'h4100_0000);
    chk("b2b_b", add_b, 32'hBF80_0000);
    tick();
    wait_rsp("b2b", 7, 32'h40E0_0000, 4'b0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Adder that never finishes
    model_en = 1'b0;
    req_a = 32'h3F80_0000; req_b = 32'h3F80_0000; req_sub = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
`ifdef FP_ADD_CTRL_TIMEOUT_EN
    wait_rsp("tmo", 17, 32'h7FC0_0000, 4'b1100);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    model_en = 1'b1;
    do_op("after_tmo", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000,
          32'h3F80_0000, 32'h4000_0000, 4'b0000, 1'b0);
    model_en = 1'b0;
    req_a = 32'h3F80_0000; req_b = 32'h3F80_0000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_tmo", {31'd0, seen}, 32'd0);
`endif

    // Asynchronous reset in WAIT, then a stray done
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {25'd0, req_ready, rsp_valid, add_load, rsp_flags}, 32'd0);
    chk("arst_ab", add_a | add_b | rsp_z, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick();
    tick();
    chk("stray_done", {30'd0, rsp_valid, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
